// File: rtl/run_controller.sv
// Run/step/breakpoint sequencer: debounces the exec button, pulses the core reset,
// gates the core clock enable and stops on HALT, breakpoint, single-step or cycle limit.
module run_controller #(
    parameter int DEB_CYCLES = 16,
    parameter int RST_CYCLES = 4,
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             exec,
    input  logic             step_mode,
    input  logic             halting,
    input  logic [11:0]      pc,
    input  logic             bp_en,
    input  logic [11:0]      bp_addr,
    output logic             cpu_en,
    output logic             cpu_rst,
    output logic [1:0]       state,
    output logic [2:0]       stop_cause,
    output logic [CNT_W-1:0] cycles
);

    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [RST_W-1:0] RST_LAST  = RST_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LIMIT_VAL = CNT_W'(MAX_CYCLES);
    localparam bit               LIMIT_ON  = (MAX_CYCLES != 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RESET = 2'd1,
        S_RUN   = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        C_NONE  = 3'd0,
        C_HALT  = 3'd1,
        C_BP    = 3'd2,
        C_STEP  = 3'd3,
        C_LIMIT = 3'd4
    } cause_t;

    // Handshake-free control: press is a single-cycle strobe, cpu_en is a level
    // the core samples on every clock edge; no backpressure exists in either direction.

    logic             exec_meta;
    logic             exec_sync;
    logic             deb_level;
    logic [DEB_W-1:0] deb_cnt;
    logic             press;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            exec_meta <= 1'b0;
            exec_sync <= 1'b0;
            deb_level <= 1'b0;
            deb_cnt   <= '0;
            press     <= 1'b0;
        end else begin
            exec_meta <= exec;
            exec_sync <= exec_meta;
            press     <= 1'b0;
            if (exec_sync == deb_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                // DEB_CYCLES consecutive differing samples: accept the new level
                deb_level <= exec_sync;
                deb_cnt   <= '0;
                press     <= exec_sync;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    state_t           state_q;
    state_t           state_d;
    cause_t           cause_q;
    cause_t           cause_d;
    cause_t           hit;
    logic [CNT_W-1:0] cycles_q;
    logic [RST_W-1:0] rst_cnt_q;
    logic             step_done_q;
    logic             bp_mask_q;
    logic             limit_off_q;
    logic             cpu_rst_q;
    logic             limit_hit;
    logic             bp_hit;
    logic             step_hit;
    logic             enter_reset;
    logic             enter_run;

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        cpu_en    = 1'b0;
        hit       = C_NONE;
        limit_hit = LIMIT_ON && !limit_off_q && (cycles_q == LIMIT_VAL);
        bp_hit    = bp_en && (pc == bp_addr) && !bp_mask_q;
        step_hit  = step_mode && step_done_q;

        if (halting) begin
            hit = C_HALT;
        end else if (limit_hit) begin
            hit = C_LIMIT;
        end else if (bp_hit) begin
            hit = C_BP;
        end else if (step_hit) begin
            hit = C_STEP;
        end

        case (state_q)
            S_IDLE: begin
                if (press) begin
                    state_d = S_RESET;
                    cause_d = C_NONE;
                end
            end
            S_RESET: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (hit != C_NONE) begin
                    state_d = S_STOP;
                    cause_d = hit;
                end else begin
                    cpu_en = 1'b1;
                end
            end
            S_STOP: begin
                if (press) begin
                    // HALT restarts the program; anything else resumes it
                    state_d = (cause_q == C_HALT) ? S_RESET : S_RUN;
                    cause_d = C_NONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cause_d = C_NONE;
            end
        endcase
    end

    assign enter_reset = (state_d == S_RESET) && (state_q != S_RESET);
    assign enter_run   = (state_d == S_RUN) && (state_q != S_RUN);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cause_q     <= C_NONE;
            cycles_q    <= '0;
            rst_cnt_q   <= '0;
            step_done_q <= 1'b0;
            bp_mask_q   <= 1'b0;
            limit_off_q <= 1'b0;
            cpu_rst_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            cpu_rst_q <= (state_d == S_RESET);
            // Masks the breakpoint for the first cycle of a resume so it can step past it
            bp_mask_q <= (state_q == S_STOP) && (state_d == S_RUN);

            if (enter_reset) begin
                cycles_q    <= '0;
                rst_cnt_q   <= '0;
                limit_off_q <= 1'b0;
            end else begin
                if (cpu_en && !(&cycles_q)) begin
                    cycles_q <= cycles_q + 1'b1;
                end
                if (state_q == S_RESET) begin
                    rst_cnt_q <= rst_cnt_q + 1'b1;
                end
                if ((state_q == S_STOP) && (state_d == S_RUN) && (cause_q == C_LIMIT)) begin
                    limit_off_q <= 1'b1;
                end
            end

            if (enter_run) begin
                step_done_q <= 1'b0;
            end else if (cpu_en) begin
                step_done_q <= 1'b1;
            end
        end
    end

    assign cpu_rst    = cpu_rst_q;
    assign state      = state_q;
    assign stop_cause = cause_q;
    assign cycles     = cycles_q;

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: a toy core (pc advances on cpu_en, clears on cpu_rst)
// and stop points predicted from halt/breakpoint/limit addresses.
module tb_run_controller;

    localparam int DEB  = 4;
    localparam int RSTC = 2;
    localparam int CW   = 8;
    localparam int MAXC = 100;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          exec = 1'b0;
    logic          step_mode = 1'b0;
    logic          halting = 1'b0;
    logic [11:0]   pc = '0;
    logic          bp_en = 1'b0;
    logic [11:0]   bp_addr = '0;
    logic          cpu_en;
    logic          cpu_rst;
    logic [1:0]    state;
    logic [2:0]    stop_cause;
    logic [CW-1:0] cycles;

    int          checks = 0;
    int          failures = 0;
    int          core_pc = 0;
    int          halt_pc = 0;
    bit          halt_armed = 1'b0;
    int          rst_seen = 0;
    logic [1:0]  p_st6;
    logic [1:0]  p_st7;
    logic [CW-1:0] p_cyc7;
    logic [31:0] exp_q[$];
    logic [31:0] exp_cause_q[$];

    always #5 clock = ~clock;

    run_controller #(
        .DEB_CYCLES(DEB),
        .RST_CYCLES(RSTC),
        .CNT_W(CW),
        .MAX_CYCLES(MAXC)
    ) dut (
        .clock(clock),
        .reset(reset),
        .exec(exec),
        .step_mode(step_mode),
        .halting(halting),
        .pc(pc),
        .bp_en(bp_en),
        .bp_addr(bp_addr),
        .cpu_en(cpu_en),
        .cpu_rst(cpu_rst),
        .state(state),
        .stop_cause(stop_cause),
        .cycles(cycles)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_halt(input bit armed, input int at);
        halt_armed = armed;
        halt_pc = at;
        halting = halt_armed && (core_pc == halt_pc);
    endtask

    // One clock of the toy core: it obeys the enable/reset it saw before the edge
    task automatic tick();
        logic en_s;
        logic rst_s;
        #1;
        en_s = cpu_en;
        rst_s = cpu_rst;
        if (rst_s) rst_seen++;
        @(posedge clock);
        #1;
        if (rst_s) core_pc = 0;
        else if (en_s) core_pc++;
        pc = 12'(core_pc);
        halting = halt_armed && (core_pc == halt_pc);
        #1;
    endtask

    task automatic press();
        exec = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 6) p_st6 = state;
            if (i == 7) begin
                p_st7 = state;
                p_cyc7 = cycles;
            end
        end
        exec = 1'b0;
        for (int i = 0; i < 8; i++) tick();
    endtask

    // Stop point from the program's point of view: the first enabled-cycle count
    // at which any stop source fires, with HALT > LIMIT > BP on ties
    task automatic predict(input int halt_at, input bit limit_on, input int bp_at);
        int best;
        int cause;
        best = 1 << 30;
        if (halt_at >= 0 && halt_at < best) best = halt_at;
        if (limit_on && MAXC < best) best = MAXC;
        if (bp_at >= 0 && bp_at < best) best = bp_at;
        if (halt_at == best) cause = 1;
        else if (limit_on && MAXC == best) cause = 4;
        else cause = 2;
        exp_q.push_back(32'(best));
        exp_cause_q.push_back(32'(cause));
    endtask

    task automatic wait_stop(input string tag);
        int n;
        logic [31:0] e_cyc;
        logic [31:0] e_cause;
        n = 0;
        e_cyc = exp_q.pop_front();
        e_cause = exp_cause_q.pop_front();
        while (state != 2'd3 && n < 400) begin
            tick();
            n++;
        end
        check({tag, "_reached_stop"}, state, 3);
        check({tag, "_cause"}, stop_cause, e_cause);
        check({tag, "_cycles"}, cycles, e_cyc);
        check({tag, "_pc"}, core_pc, e_cyc);
        check({tag, "_cpu_en"}, cpu_en, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int h_at;
        int b_at;
        int glen;
        int nsteps;
        int n;

        h_at = $urandom_range(20, 60);
        b_at = $urandom_range(20, 50);
        glen = $urandom_range(1, 3);
        nsteps = $urandom_range(3, 5);

        // Reset state
        repeat (3) tick();
        check("rst_state", state, 0);
        check("rst_cpu_en", cpu_en, 0);
        check("rst_cpu_rst", cpu_rst, 0);
        check("rst_cycles", cycles, 0);
        check("rst_cause", stop_cause, 0);
        reset = 1'b0;
        repeat (2) tick();

        // Short glitch is filtered
        exec = 1'b1;
        repeat (glen) tick();
        exec = 1'b0;
        repeat (12) tick();
        check("glitch_state", state, 0);
        check("glitch_no_rst", rst_seen, 0);

        // Held press starts the program; run to HALT
        set_halt(1'b1, h_at);
        predict(h_at, 1'b1, -1);
        press();
        check("press_lat_before", p_st6, 0);
        check("press_lat_reset", p_st7, 1);
        check("press_rst_len", rst_seen, RSTC);
        check("run_state", state, 2);
        check("run_cpu_en", cpu_en, 1);
        check("run_count", cycles, core_pc);
        wait_stop("halt");
        repeat (3) tick();
        check("halt_hold_cycles", cycles, h_at);
        check("halt_hold_state", state, 3);

        // Restart from HALT with a breakpoint armed
        set_halt(1'b0, 0);
        bp_en = 1'b1;
        bp_addr = 12'(b_at);
        predict(-1, 1'b1, b_at);
        press();
        check("restart_reset", p_st7, 1);
        check("restart_cycles0", p_cyc7, 0);
        wait_stop("bp");
        repeat (2) tick();
        check("bp_pc_frozen", core_pc, b_at);

        // Resume steps past the breakpoint
        press();
        check("bp_resume_run", p_st7, 2);
        check("bp_resume_state", state, 2);
        check("bp_resume_cause", stop_cause, 0);
        check("bp_resume_past", (core_pc > b_at), 1);

        // Press while running is ignored
        rst_seen = 0;
        press();
        check("run_press_state", state, 2);
        check("run_press_no_rst", rst_seen, 0);
        bp_en = 1'b0;

        // step_mode raised mid-run stops at once
        step_mode = 1'b1;
        #1;
        check("step_toggle_en", cpu_en, 0);
        tick();
        check("step_toggle_state", state, 3);
        check("step_toggle_cause", stop_cause, 3);
        step_mode = 1'b0;
        predict(-1, 1'b1, -1);
        press();
        check("step_resume", state, 2);
        wait_stop("limit");

        // Resume from LIMIT: limit disarmed, counter saturates
        press();
        check("lim_resume_state", state, 2);
        check("lim_resume_cause", stop_cause, 0);
        check("lim_resume_past", (cycles > 8'd100), 1);
        n = 0;
        while (cycles != 8'hFF && n < 400) begin
            tick();
            n++;
        end
        repeat (5) tick();
        check("sat_cycles", cycles, 255);
        check("sat_cpu_en", cpu_en, 1);
        check("sat_state", state, 2);

        // HALT while saturated
        set_halt(1'b1, core_pc);
        #1;
        check("halt_now_en", cpu_en, 0);
        tick();
        check("halt_now_state", state, 3);
        check("halt_now_cause", stop_cause, 1);
        check("halt_now_cycles", cycles, 255);

        // Single-step from a fresh restart: one enabled cycle per press
        set_halt(1'b0, 0);
        step_mode = 1'b1;
        press();
        check("step0_reset", p_st7, 1);
        check("step0_cycles0", p_cyc7, 0);
        check("step0_state", state, 3);
        check("step0_cause", stop_cause, 3);
        check("step0_cycles", cycles, 1);
        for (int k = 1; k <= nsteps; k++) begin
            press();
            check("stepk_resume", p_st7, 2);
            check("stepk_cycles", cycles, 1 + k);
            check("stepk_pc", core_pc, 1 + k);
            check("stepk_cause", stop_cause, 3);
        end

        // HALT and LIMIT on the same cycle
        step_mode = 1'b0;
        set_halt(1'b1, MAXC);
        predict(MAXC, 1'b1, -1);
        press();
        wait_stop("tie");

        // Async reset mid-run
        set_halt(1'b0, 0);
        press();
        repeat ($urandom_range(3, 10)) tick();
        check("pre_areset_state", state, 2);
        #2;
        reset = 1'b1;
        #1;
        check("areset_state", state, 0);
        check("areset_cpu_en", cpu_en, 0);
        check("areset_cycles", cycles, 0);
        check("areset_cpu_rst", cpu_rst, 0);
        check("areset_cause", stop_cause, 0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (3) tick();
        check("post_areset_state", state, 0);
        check("post_areset_cycles", cycles, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
